mp64_sram_arb2: RTL and testbench
=================================

Name: mp64_sram_arb2

Overview:
- Two-requester controller for one single-port SRAM (mp64_sram_sp): round-robin arbitration, read-response routing by requester, and an optional zero-fill of the array after reset.
- Sits between two masters (e.g. core port A and DMA port B) and one SRAM instance.
- Issues at most one SRAM access per cycle and sustains one access per cycle.

Parameters:
- ADDR_W, 14: SRAM address width.
- DATA_W, 512: SRAM data width.
- DEPTH, (1 << ADDR_W): number of words cleared by the init sequence.
- RD_LAT, 1: SRAM read latency in cycles. Legal values are 1 or 2; it must equal 1 + the SRAM's OUT_REG.
- CLEAR_ON_RST, 1: when 1, zero-fill words 0..DEPTH-1 after reset release.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- a_req_valid  in  1  port A request valid.
- a_req_ready  out  1  port A request accepted this cycle.
- a_req_we  in  1  1 = write, 0 = read.
- a_req_addr  in  ADDR_W  word address.
- a_req_wdata  in  DATA_W  write data.
- a_rsp_valid  out  1  port A read data valid (one-cycle pulse).
- a_rsp_rdata  out  DATA_W  port A read data.
- b_req_valid, b_req_ready, b_req_we, b_req_addr, b_req_wdata, b_rsp_valid, b_rsp_rdata: as for port A.
- sram_ce  out  1  SRAM chip enable.
- sram_we  out  1  SRAM write enable.
- sram_addr  out  ADDR_W  SRAM address.
- sram_wdata  out  DATA_W  SRAM write data.
- sram_rdata  in  DATA_W  SRAM read data.
- init_busy  out  1  clear sequence in progress.

Behaviour:
- Reset values while rst_n = 0:
  - state = BOOT, clr_cnt = 0, last_grant = B, rd pipeline empty.
  - a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, sram_ce, sram_we = 0.
  - init_busy = CLEAR_ON_RST.
- FSM states are BOOT, CLEAR and RUN.
  - BOOT: the first clk edge after rst_n rises moves to CLEAR if CLEAR_ON_RST, else to RUN.
  - CLEAR: each cycle drives sram_ce = 1, sram_we = 1, sram_addr = clr_cnt, sram_wdata = 0, then clr_cnt++.
  - CLEAR exit: after the write with clr_cnt = DEPTH-1, go to RUN. The counter does not wrap. init_busy falls on the RUN entry edge.
  - RUN: terminal until reset.
- In BOOT and CLEAR, both req_ready = 0. Requests hold valid/addr/we/wdata stable until ready.
- Arbitration (RUN only, combinational):
  - Only A valid: grant A. Only B valid: grant B.
  - Both valid: grant the port that is not last_grant.
  - last_grant updates to the granted port on every grant.
  - Because last_grant resets to B, A wins the first contention.
- Grant effects:
  - x_req_ready = 1 for the granted port only.
  - sram_ce = 1; sram_we, sram_addr and sram_wdata come from the granted port.
  - sram_ce = 0 and sram_we = 0 when no valid request is present.
  - Ready does not depend on any response backpressure. Throughput is 1 access per cycle.
- Read responses:
  - An accepted read pushes the requester id into an RD_LAT-deep valid/id shift pipeline.
  - Exactly RD_LAT cycles after the acceptance edge, the matching x_rsp_valid = 1 for one cycle.
  - x_rsp_rdata = sram_rdata (combinational pass-through, valid only when rsp_valid).
  - Responses cannot be stalled; a requester must always sink them.
  - Responses return in issue order.
- Writes produce no response. Write data is visible to a read accepted on the next cycle from either port.
  - Same-cycle hazards are impossible because only one access is issued per cycle.
- Asserting rst_n mid-CLEAR or mid-RUN:
  - Returns all state to reset values immediately and discards in-flight responses.
  - A post-reset clear restarts from address 0.
- sram_wdata when idle is don't-care. sram_addr when idle holds the last value or 0, implementer's choice, but must be X-free.

Test Plan:
- Clear: ADDR_W=4, CLEAR_ON_RST=1, release reset with A read addr 5 pending -> one BOOT cycle, then 16 consecutive sram_ce=1/we=1 cycles on addr 0..15 with wdata 0 while a_req_ready=0 and init_busy=1. Next cycle init_busy=0, A read granted, a_rsp_valid 1 cycle later with rdata 0.
- Contention: A and B both continuously request reads of addr 1 and 2 -> grants alternate A,B,A,B. Each rsp_valid arrives on its own port with the correct data, and no pulse ever reaches the other port.
- Latency: RD_LAT=2, OUT_REG=1 SRAM, A writes 0xDEAD at addr 3, then B reads addr 3 on the next cycle -> b_rsp_valid exactly 2 cycles after b_req_ready, rdata 0xDEAD, and a_rsp_valid never pulses.
- Single requester: B alone valid for 4 cycles with A idle -> b_req_ready=1 on all 4 cycles with no bubbles; then first A request while B still valid -> A granted.
- Reset mid-operation: assert rst_n at clr_cnt=7 -> outputs return to reset values asynchronously (without waiting for a clock edge); after release the clear restarts at addr 0. Assert reset with a read in flight -> no rsp_valid pulse after release.
- No clear: CLEAR_ON_RST=0 -> init_busy=0 throughout; a request is granted on the second cycle after reset release (after BOOT).

Source files
------------

// File: rtl/mp64_sram_arb2.sv
// Two-requester front end for one single-port SRAM.
// Round-robin arbitration between ports A and B, read responses routed back
// to the requester through an RD_LAT-deep id pipeline, and an optional
// zero-fill of the whole array after reset release.
module mp64_sram_arb2 #(
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 512,
    parameter int DEPTH        = (1 << ADDR_W),
    parameter int RD_LAT       = 1,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              a_req_valid_i,
    output logic              a_req_ready_o,
    input  logic              a_req_we_i,
    input  logic [ADDR_W-1:0] a_req_addr_i,
    input  logic [DATA_W-1:0] a_req_wdata_i,
    output logic              a_rsp_valid_o,
    output logic [DATA_W-1:0] a_rsp_rdata_o,

    input  logic              b_req_valid_i,
    output logic              b_req_ready_o,
    input  logic              b_req_we_i,
    input  logic [ADDR_W-1:0] b_req_addr_i,
    input  logic [DATA_W-1:0] b_req_wdata_i,
    output logic              b_rsp_valid_o,
    output logic [DATA_W-1:0] b_rsp_rdata_o,

    output logic              sram_ce_o,
    output logic              sram_we_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [DATA_W-1:0] sram_wdata_o,
    input  logic [DATA_W-1:0] sram_rdata_i,

    output logic              init_busy_o
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    // Last word written by the clear sequence; the counter stops here.
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

    // Grant history encoding: 0 = A, 1 = B.
    localparam logic GNT_A = 1'b0;
    localparam logic GNT_B = 1'b1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              last_grant_q, last_grant_d;
    logic              grant_a, grant_b;
    logic              rd_push;

    // Read pipeline: valid bit and requester id per stage (id 1 = B).
    logic [RD_LAT-1:0] rd_vld_q, rd_vld_d;
    logic [RD_LAT-1:0] rd_id_q,  rd_id_d;

    // State, clear counter and round-robin history registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_BOOT;
            clr_cnt_q    <= '0;
            last_grant_q <= GNT_B;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Next-state logic, arbitration and SRAM command mux.
    always_comb begin
        state_d       = state_q;
        clr_cnt_d     = clr_cnt_q;
        last_grant_d  = last_grant_q;
        grant_a       = 1'b0;
        grant_b       = 1'b0;
        a_req_ready_o = 1'b0;
        b_req_ready_o = 1'b0;
        sram_ce_o     = 1'b0;
        sram_we_o     = 1'b0;
        sram_addr_o   = '0;
        sram_wdata_o  = '0;

        case (state_q)
            ST_BOOT: begin
                state_d = (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_RUN;
            end

            ST_CLEAR: begin
                sram_ce_o   = 1'b1;
                sram_we_o   = 1'b1;
                sram_addr_o = clr_cnt_q;
                if (clr_cnt_q == CLR_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end

            ST_RUN: begin
                // A wins when alone, or on contention when B was served last.
                grant_a = a_req_valid_i && (!b_req_valid_i || (last_grant_q == GNT_B));
                grant_b = b_req_valid_i && !grant_a;
                if (grant_a) begin
                    a_req_ready_o = 1'b1;
                    sram_ce_o     = 1'b1;
                    sram_we_o     = a_req_we_i;
                    sram_addr_o   = a_req_addr_i;
                    sram_wdata_o  = a_req_wdata_i;
                    last_grant_d  = GNT_A;
                end else if (grant_b) begin
                    b_req_ready_o = 1'b1;
                    sram_ce_o     = 1'b1;
                    sram_we_o     = b_req_we_i;
                    sram_addr_o   = b_req_addr_i;
                    sram_wdata_o  = b_req_wdata_i;
                    last_grant_d  = GNT_B;
                end
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    assign rd_push = (grant_a && !a_req_we_i) || (grant_b && !b_req_we_i);

    // Stage 0 captures accepted reads; later stages just shift.
    genvar gi;
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_rd_pipe
            if (gi == 0) begin : g_head
                assign rd_vld_d[gi] = rd_push;
                assign rd_id_d[gi]  = grant_b;
            end else begin : g_tail
                assign rd_vld_d[gi] = rd_vld_q[gi-1];
                assign rd_id_d[gi]  = rd_id_q[gi-1];
            end
        end
    endgenerate

    // Read-response pipeline; reset drops anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_q <= '0;
            rd_id_q  <= '0;
        end else begin
            rd_vld_q <= rd_vld_d;
            rd_id_q  <= rd_id_d;
        end
    end

    assign a_rsp_valid_o = rd_vld_q[RD_LAT-1] && !rd_id_q[RD_LAT-1];
    assign b_rsp_valid_o = rd_vld_q[RD_LAT-1] &&  rd_id_q[RD_LAT-1];
    assign a_rsp_rdata_o = sram_rdata_i;
    assign b_rsp_rdata_o = sram_rdata_i;

    // Busy covers BOOT and CLEAR, and only when a clear is configured.
    assign init_busy_o = (CLEAR_ON_RST != 0) && (state_q != ST_RUN);

endmodule

// File: tb/tb_mp64_sram_arb2.sv
// Directed bench for mp64_sram_arb2. Instance 0: 16-word array, clear on
// reset, 1-cycle SRAM. Instance 1: no clear, 2-cycle (output-registered) SRAM.
module tb_mp64_sram_arb2;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam logic [DW-1:0] D1 = 32'h1111_0001;
    localparam logic [DW-1:0] D2 = 32'h2222_0002;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks_cnt = 0;
    int errors_cnt = 0;

    // ---------------- instance 0 signals ----------------
    logic          rst0_n;
    logic          a0_valid, a0_ready, a0_we, a0_rsp;
    logic [AW-1:0] a0_addr;
    logic [DW-1:0] a0_wdata, a0_rdata;
    logic          b0_valid, b0_ready, b0_we, b0_rsp;
    logic [AW-1:0] b0_addr;
    logic [DW-1:0] b0_wdata, b0_rdata;
    logic          s0_ce, s0_we, busy0;
    logic [AW-1:0] s0_addr;
    logic [DW-1:0] s0_wdata, s0_rdata;

    // ---------------- instance 1 signals ----------------
    logic          rst1_n;
    logic          a1_valid, a1_ready, a1_we, a1_rsp;
    logic [AW-1:0] a1_addr;
    logic [DW-1:0] a1_wdata, a1_rdata;
    logic          b1_valid, b1_ready, b1_we, b1_rsp;
    logic [AW-1:0] b1_addr;
    logic [DW-1:0] b1_wdata, b1_rdata;
    logic          s1_ce, s1_we, busy1;
    logic [AW-1:0] s1_addr;
    logic [DW-1:0] s1_wdata, s1_rdata;

    mp64_sram_arb2 #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(16), .RD_LAT(1), .CLEAR_ON_RST(1)) u_dut0 (
        .clk(clk), .rst_n(rst0_n),
        .a_req_valid_i(a0_valid), .a_req_ready_o(a0_ready), .a_req_we_i(a0_we),
        .a_req_addr_i(a0_addr), .a_req_wdata_i(a0_wdata),
        .a_rsp_valid_o(a0_rsp), .a_rsp_rdata_o(a0_rdata),
        .b_req_valid_i(b0_valid), .b_req_ready_o(b0_ready), .b_req_we_i(b0_we),
        .b_req_addr_i(b0_addr), .b_req_wdata_i(b0_wdata),
        .b_rsp_valid_o(b0_rsp), .b_rsp_rdata_o(b0_rdata),
        .sram_ce_o(s0_ce), .sram_we_o(s0_we), .sram_addr_o(s0_addr),
        .sram_wdata_o(s0_wdata), .sram_rdata_i(s0_rdata),
        .init_busy_o(busy0)
    );

    mp64_sram_arb2 #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(16), .RD_LAT(2), .CLEAR_ON_RST(0)) u_dut1 (
        .clk(clk), .rst_n(rst1_n),
        .a_req_valid_i(a1_valid), .a_req_ready_o(a1_ready), .a_req_we_i(a1_we),
        .a_req_addr_i(a1_addr), .a_req_wdata_i(a1_wdata),
        .a_rsp_valid_o(a1_rsp), .a_rsp_rdata_o(a1_rdata),
        .b_req_valid_i(b1_valid), .b_req_ready_o(b1_ready), .b_req_we_i(b1_we),
        .b_req_addr_i(b1_addr), .b_req_wdata_i(b1_wdata),
        .b_rsp_valid_o(b1_rsp), .b_rsp_rdata_o(b1_rdata),
        .sram_ce_o(s1_ce), .sram_we_o(s1_we), .sram_addr_o(s1_addr),
        .sram_wdata_o(s1_wdata), .sram_rdata_i(s1_rdata),
        .init_busy_o(busy1)
    );

    // SRAM model, 1-cycle read latency.
    logic [DW-1:0] mem0 [16];
    logic [DW-1:0] rd0_q;
    always @(posedge clk) begin
        if (s0_ce) begin
            if (s0_we) mem0[s0_addr] <= s0_wdata;
            else       rd0_q <= mem0[s0_addr];
        end
    end
    assign s0_rdata = rd0_q;

    // SRAM model with output register, 2-cycle read latency.
    logic [DW-1:0] mem1 [16];
    logic [DW-1:0] rd1_a, rd1_q;
    always @(posedge clk) begin
        if (s1_ce) begin
            if (s1_we) mem1[s1_addr] <= s1_wdata;
            else       rd1_a <= mem1[s1_addr];
        end
        rd1_q <= rd1_a;
    end
    assign s1_rdata = rd1_q;

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    // Expect n clear writes on instance 0 starting at address 0.
    task automatic chk_clear(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); #1;
            check_val($sformatf("clr%0d_cmd", i),
                      {24'd0, s0_ce, s0_we, a0_ready, busy0, s0_addr},
                      {24'd0, 1'b1, 1'b1, 1'b0, 1'b1, 4'(i)});
            check_val($sformatf("clr%0d_wdata", i), s0_wdata, '0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst0_n = 1'b0; rst1_n = 1'b0;
        a0_valid = 0; a0_we = 0; a0_addr = '0; a0_wdata = '0;
        b0_valid = 0; b0_we = 0; b0_addr = '0; b0_wdata = '0;
        a1_valid = 0; a1_we = 0; a1_addr = '0; a1_wdata = '0;
        b1_valid = 0; b1_we = 0; b1_addr = '0; b1_wdata = '0;
        #12;
        check_val("rst_a_ready", a0_ready, 0);
        check_val("rst_b_ready", b0_ready, 0);
        check_val("rst_ce", s0_ce, 0);
        check_val("rst_we", s0_we, 0);
        check_val("rst_busy0", busy0, 1);
        check_val("rst_a_rsp", a0_rsp, 0);
        check_val("rst_b_rsp", b0_rsp, 0);
        check_val("rst_busy1", busy1, 0);

        // ---- clear after reset with A read of addr 5 pending ----
        a0_valid = 1; a0_we = 0; a0_addr = 4'd5;
        @(negedge clk); rst0_n = 1'b1; #1;
        check_val("boot_ce", s0_ce, 0);
        check_val("boot_a_ready", a0_ready, 0);
        check_val("boot_busy", busy0, 1);
        chk_clear(16);
        @(negedge clk); #1;
        check_val("run_busy", busy0, 0);
        check_val("run_a_ready", a0_ready, 1);
        check_val("run_addr", s0_addr, 5);
        check_val("run_we", s0_we, 0);
        // A write addr 1 while the addr-5 read response comes back
        @(negedge clk); a0_we = 1; a0_addr = 4'd1; a0_wdata = D1; #1;
        check_val("rd5_a_rsp", a0_rsp, 1);
        check_val("rd5_rdata", a0_rdata, 0);
        check_val("rd5_b_rsp", b0_rsp, 0);
        check_val("wr1_a_ready", a0_ready, 1);
        @(negedge clk); a0_valid = 0; b0_valid = 1; b0_we = 1; b0_addr = 4'd2; b0_wdata = D2; #1;
        check_val("wr2_b_ready", b0_ready, 1);
        check_val("wr1_no_rsp", a0_rsp, 0);

        // ---- contention: both read continuously, expect A,B,A,B ----
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) begin
                a0_valid = 1; a0_we = 0; a0_addr = 4'd1;
                b0_we = 0; b0_addr = 4'd2;
            end
            if (k == 4) begin a0_valid = 0; b0_valid = 0; end
            #1;
            if (k < 4) begin
                check_val($sformatf("cont%0d_a_ready", k), a0_ready, (k % 2 == 0));
                check_val($sformatf("cont%0d_b_ready", k), b0_ready, (k % 2 == 1));
            end
            if (k == 0) begin
                check_val("cont0_a_rsp", a0_rsp, 0);
                check_val("cont0_b_rsp", b0_rsp, 0);
            end else if ((k - 1) % 2 == 0) begin
                check_val($sformatf("cont%0d_a_rsp", k), a0_rsp, 1);
                check_val($sformatf("cont%0d_b_rsp", k), b0_rsp, 0);
                check_val($sformatf("cont%0d_a_data", k), a0_rdata, D1);
            end else begin
                check_val($sformatf("cont%0d_a_rsp", k), a0_rsp, 0);
                check_val($sformatf("cont%0d_b_rsp", k), b0_rsp, 1);
                check_val($sformatf("cont%0d_b_data", k), b0_rdata, D2);
            end
        end

        // ---- single requester B, then A joins and wins ----
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (k == 0) begin b0_valid = 1; b0_we = 0; b0_addr = 4'd2; end
            if (k == 4) begin a0_valid = 1; a0_we = 0; a0_addr = 4'd1; end
            if (k == 5) a0_valid = 0;
            if (k == 6) b0_valid = 0;
            #1;
            if (k < 4 || k == 5) begin
                check_val($sformatf("solo%0d_b_ready", k), b0_ready, 1);
                check_val($sformatf("solo%0d_a_ready", k), a0_ready, 0);
            end
            if (k == 4) begin
                check_val("solo4_a_ready", a0_ready, 1);
                check_val("solo4_b_ready", b0_ready, 0);
            end
            if (k == 0) begin
                check_val("solo0_b_rsp", b0_rsp, 0);
            end else if (k == 5) begin
                check_val("solo5_a_rsp", a0_rsp, 1);
                check_val("solo5_a_data", a0_rdata, D1);
                check_val("solo5_b_rsp", b0_rsp, 0);
            end else begin
                check_val($sformatf("solo%0d_b_rsp", k), b0_rsp, 1);
                check_val($sformatf("solo%0d_b_data", k), b0_rdata, D2);
                check_val($sformatf("solo%0d_a_rsp", k), a0_rsp, 0);
            end
        end

        // ---- reset with a read in flight ----
        @(negedge clk); a0_valid = 1; a0_we = 0; a0_addr = 4'd1; #1;
        check_val("fly_a_ready", a0_ready, 1);
        @(posedge clk); #2; rst0_n = 1'b0; #1;
        check_val("fly_rst_a_rsp", a0_rsp, 0);
        check_val("fly_rst_a_ready", a0_ready, 0);
        check_val("fly_rst_ce", s0_ce, 0);
        check_val("fly_rst_busy", busy0, 1);
        a0_valid = 0;
        @(negedge clk);
        @(negedge clk); rst0_n = 1'b1; #1;
        check_val("fly_rel_a_rsp", a0_rsp, 0);
        check_val("fly_rel_ce", s0_ce, 0);

        // ---- reset at clr_cnt = 7, clear restarts from 0 ----
        chk_clear(8);
        #1; rst0_n = 1'b0; #1;
        check_val("mid_rst_ce", s0_ce, 0);
        check_val("mid_rst_we", s0_we, 0);
        check_val("mid_rst_busy", busy0, 1);
        @(negedge clk); rst0_n = 1'b1; #1;
        check_val("mid_boot_ce", s0_ce, 0);
        chk_clear(16);
        @(negedge clk); a0_valid = 1; a0_we = 0; a0_addr = 4'd1; #1;
        check_val("post_a_ready", a0_ready, 1);
        check_val("post_busy", busy0, 0);
        @(negedge clk); a0_valid = 0; #1;
        check_val("post_a_rsp", a0_rsp, 1);
        check_val("post_cleared", a0_rdata, 0);

        // ---- instance 1: no clear, RD_LAT = 2 ----
        a1_valid = 1; a1_we = 1; a1_addr = 4'd3; a1_wdata = 32'h0000_DEAD;
        @(negedge clk); rst1_n = 1'b1; #1;
        check_val("nc_boot_a_ready", a1_ready, 0);
        check_val("nc_boot_busy", busy1, 0);
        @(negedge clk); #1;
        check_val("nc_wr_a_ready", a1_ready, 1);
        check_val("nc_wr_we", s1_we, 1);
        check_val("nc_wr_addr", s1_addr, 3);
        check_val("nc_busy", busy1, 0);
        @(negedge clk); a1_valid = 0; b1_valid = 1; b1_we = 0; b1_addr = 4'd3; #1;
        check_val("lat_b_ready", b1_ready, 1);
        check_val("lat_ce", s1_ce, 1);
        check_val("lat_we", s1_we, 0);
        @(negedge clk); b1_valid = 0; #1;
        check_val("lat1_b_rsp", b1_rsp, 0);
        check_val("lat1_a_rsp", a1_rsp, 0);
        @(negedge clk); #1;
        check_val("lat2_b_rsp", b1_rsp, 1);
        check_val("lat2_b_data", b1_rdata, 32'h0000_DEAD);
        check_val("lat2_a_rsp", a1_rsp, 0);
        @(negedge clk); #1;
        check_val("lat3_b_rsp", b1_rsp, 0);
        check_val("lat3_a_rsp", a1_rsp, 0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
